uart_tx_engine: RTL and testbench

- Transmit-side UART engine. It is the partner of the team's UART receiver and drives that receiver's `rx` line in loopback benches.
- Accepts bytes through a CPU-style write strobe into a small FIFO.
- Serialises each byte as 8N1 (or 8E1 with the option below), LSB first.
- Raises a per-frame completion interrupt that can be masked.

---
 rtl/uart_tx_engine.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO feeding an 8N1 serialiser with a maskable end-of-frame pulse.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7 (8E1 framing).
module uart_tx_engine #(
    parameter int DIV        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       we,
    input  logic [7:0] dat,
    input  logic       dis_int,
    output logic       tx,
    output logic       full,
    output logic       busy,
    output logic       inter,
    output logic       ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_ovf;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_inter;
`ifdef UART_TX_PARITY_EN
    logic          r_par;
`endif

    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic          w_last;
    logic [7:0]    w_head;
    logic [AW:0]   w_count_nxt;

    assign w_nonempty = (r_count != '0);
    assign w_last     = (r_cnt == '0);
    assign w_head     = r_mem[r_rptr];
    assign w_push     = we && !r_full;
    // The FSM takes the head byte when idle or on the final stop-bit cycle, so frames chain gap-free.
    assign w_pop      = w_nonempty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_last));

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= dat;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            if (we && r_full)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_inter <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_inter <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_nonempty) begin
                        r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^w_head;
`endif
                        r_cnt   <= CNT_MAX;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_last) begin
                        r_cnt   <= CNT_MAX;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_last) begin
                        r_cnt <= CNT_MAX;
                        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_last) begin
                        r_cnt   <= CNT_MAX;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // Registered one cycle early so the pulse coincides with the last stop-bit cycle.
                    if (r_cnt == CW'(1))
                        r_inter <= !dis_int;
                    if (w_last) begin
                        if (w_nonempty) begin
                            r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_par   <= ^w_head;
`endif
                            r_cnt   <= CNT_MAX;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx    = r_tx;
    assign inter = r_inter;
    assign full  = r_full;
    assign ovf   = r_ovf;
    assign busy  = (r_state != S_IDLE) || w_nonempty;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: a serial monitor decodes tx frames and checks them against queued bytes.
module tb_uart_tx_engine;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FLEN = NBITS * DIV;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       we = 1'b0;
    logic [7:0] dat = 8'h00;
    logic       dis_int = 1'b0;
    logic       tx, full, busy, inter, ovf;

    uart_tx_engine #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .arst(arst), .we(we), .dat(dat), .dis_int(dis_int),
        .tx(tx), .full(full), .busy(busy), .inter(inter), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        bit         ie;
    } exp_t;

    exp_t q[$];
    int   starts[$];
    int   inter_cyc[$];
    int   checks = 0;
    int   errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Serial receiver acting as the scoreboard consumer
    bit          mon_busy = 0;
    int          mon_s;
    logic [10:0] mon_bits;
    int          mon_unstable;
    int          mon_nint;
    bit          mon_int_last;
    exp_t        cur;

    always @(negedge clk) begin
        if (arst !== 1'b1) begin
            mon_busy = 0;
        end else begin
            if (inter === 1'b1)
                inter_cyc.push_back(cyc);
            if (!mon_busy && tx === 1'b0) begin
                mon_busy = 1;
                mon_s = cyc;
                starts.push_back(cyc);
                mon_bits = '1;
                mon_unstable = 0;
                mon_nint = 0;
                mon_int_last = 0;
                if (q.size() == 0) begin
                    chk("sb_unexpected_frame", 1, 0);
                    cur.b = 8'h00;
                    cur.ie = 1'b0;
                end else begin
                    cur = q.pop_front();
                end
            end else if (!mon_busy && inter === 1'b1) begin
                chk("sb_stray_inter", 1, 0);
            end
            if (mon_busy) begin
                int off, bi;
                off = cyc - mon_s;
                bi = off / DIV;
                if (off % DIV == 0)
                    mon_bits[bi] = tx;
                else if (tx !== mon_bits[bi])
                    mon_unstable++;
                if (inter === 1'b1) begin
                    mon_nint++;
                    if (off == FLEN - 1)
                        mon_int_last = 1;
                end
                if (off == FLEN - 1) begin
                    chk("sb_start_bit", mon_bits[0], 0);
                    chk("sb_data", mon_bits[8:1], cur.b);
`ifdef UART_TX_PARITY_EN
                    chk("sb_parity", mon_bits[9], ^cur.b);
`endif
                    chk("sb_stop_bit", mon_bits[NBITS-1], 1);
                    chk("sb_bit_stable", mon_unstable, 0);
                    chk("sb_inter_count", mon_nint, cur.ie ? 1 : 0);
                    if (cur.ie)
                        chk("sb_inter_pos", mon_int_last, 1);
                    mon_busy = 0;
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while ((busy !== 1'b0 || mon_busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, (t < 3000) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic drive_push(input logic [7:0] b, input bit ie, input bit accepted);
        dat = b;
        we = 1'b1;
        if (accepted) begin
            exp_t e;
            e.b = b;
            e.ie = ie;
            q.push_back(e);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n0, unst, ipos, icnt, lows, bhigh;
        logic [10:0] expv;
        logic smp [0:63];
        logic ismp [0:63];
        logic bsmp [0:63];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inter", inter, 0);
        chk("rst_ovf", ovf, 0);
        arst = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5
`ifdef UART_TX_PARITY_EN
        expv = 11'b10101001010;
`else
        expv = 11'b01101001010;
`endif
        drive_push(8'hA5, 1'b1, 1'b1);
        k = cyc + 1;
        @(negedge clk);
        we = 1'b0;
        for (int i = 1; i <= FLEN + 1; i++) begin
            @(negedge clk);
            smp[i] = tx;
            ismp[i] = inter;
            bsmp[i] = busy;
        end
        unst = 0;
        for (int j = 0; j < NBITS; j++) begin
            chk($sformatf("a5_bit%0d", j), smp[1 + j*DIV], expv[j]);
            for (int s = 1; s < DIV; s++)
                if (smp[1 + j*DIV + s] !== smp[1 + j*DIV]) unst++;
        end
        chk("a5_bit_stable", unst, 0);
        ipos = -1;
        icnt = 0;
        for (int i = 1; i <= FLEN + 1; i++)
            if (ismp[i] === 1'b1) begin
                icnt++;
                if (ipos < 0) ipos = i;
            end
        chk("a5_inter_pos", ipos, FLEN);
        chk("a5_inter_count", icnt, 1);
        chk("a5_busy_last_stop", bsmp[FLEN], 1);
        chk("a5_busy_drop", bsmp[FLEN + 1], 0);
        chk("a5_k_consistent", cyc, k + FLEN + 1);
        wait_idle("a5_idle_timeout");

        // Back-to-back 0x00, 0xFF
        n0 = starts.size();
        ipos = inter_cyc.size();
        drive_push(8'h00, 1'b1, 1'b1);
        @(negedge clk);
        drive_push(8'hFF, 1'b1, 1'b1);
        @(negedge clk);
        we = 1'b0;
        wait_idle("b2b_idle_timeout");
        chk("b2b_frames", starts.size() - n0, 2);
        chk("b2b_inters", inter_cyc.size() - ipos, 2);
        if (starts.size() - n0 == 2)
            chk("b2b_start_gap", starts[n0 + 1] - starts[n0], FLEN);
        if (inter_cyc.size() - ipos == 2)
            chk("b2b_inter_gap", inter_cyc[ipos + 1] - inter_cyc[ipos], FLEN);

        // Overflow: first byte goes straight to the shifter, four fill the FIFO, sixth is dropped
        n0 = starts.size();
        drive_push(8'h11, 1'b1, 1'b1);
        @(negedge clk);
        drive_push(8'h22, 1'b1, 1'b1);
        @(negedge clk);
        drive_push(8'h33, 1'b1, 1'b1);
        @(negedge clk);
        drive_push(8'h44, 1'b1, 1'b1);
        @(negedge clk);
        chk("ovf_full_before", full, 0);
        drive_push(8'h55, 1'b1, 1'b1);
        @(negedge clk);
        chk("ovf_full_after", full, 1);
        chk("ovf_not_yet", ovf, 0);
        drive_push(8'h66, 1'b1, 1'b0);
        @(negedge clk);
        we = 1'b0;
        chk("ovf_set", ovf, 1);
        wait_idle("ovf_idle_timeout");
        chk("ovf_sticky", ovf, 1);
        chk("ovf_frames", starts.size() - n0, 5);
        chk("ovf_full_clear", full, 0);

        // Interrupt mask
        dis_int = 1'b1;
        ipos = inter_cyc.size();
        drive_push(8'h3C, 1'b0, 1'b1);
        @(negedge clk);
        we = 1'b0;
        wait_idle("mask_idle_timeout");
        chk("mask_no_inter", inter_cyc.size() - ipos, 0);
        dis_int = 1'b0;

        // Reset during data bit 3 of 0x55
        drive_push(8'h55, 1'b1, 1'b1);
        k = cyc + 1;
        @(negedge clk);
        we = 1'b0;
        while (cyc < k + 1 + 4*DIV + 1) @(negedge clk);
        #1 arst = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_full", full, 0);
        chk("rst_mid_ovf", ovf, 0);
        repeat (2) @(negedge clk);
        arst = 1'b1;
        lows = 0;
        bhigh = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) bhigh++;
        end
        chk("rst_after_tx_low_cycles", lows, 0);
        chk("rst_after_busy_cycles", bhigh, 0);

`ifdef UART_TX_PARITY_EN
        // Parity frame 0x07
        drive_push(8'h07, 1'b1, 1'b1);
        k = cyc + 1;
        @(negedge clk);
        we = 1'b0;
        while (cyc < k + 1 + 9*DIV) @(negedge clk);
        chk("par_bit", tx, 1);
        wait_idle("par_idle_timeout");
        if (starts.size() > 0 && inter_cyc.size() > 0)
            chk("par_frame_len", inter_cyc[inter_cyc.size()-1] - starts[starts.size()-1] + 1, 44);
`endif

        chk("sb_queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
